if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset vector
// and a small alignment helper.
package riscv_pkg;

   // Fetch-stage controller states.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } if_state_e;

   // Byte address of the first instruction fetched after reset.
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   // Instruction addresses must be word aligned (no compressed support).
   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and its PC.
// Control priority is flush > hold > load. A flush clears only the valid bit;
// pc and instr keep their last value so they stay deterministic while invalid.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   // Register update: flush drops the instruction, hold freezes, else load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         pc_o    <= 32'h0;
         instr_o <= 32'h0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (!hold_i) begin
         valid_o <= 1'b1;
         pc_o    <= pc_i;
         instr_o <= instr_i;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the
// BOOT/RUN/FAULT controller, feeding the IF/ID register.
//
// id_valid_o is a plain qualifier with no back-pressure: when it is 1 the
// id_pc_o/id_instr_o pair is a real instruction; the downstream stage
// throttles fetch only through stall_i. Redirects always win over stalls.
module if_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic        fault_o,
   output logic [31:0] fault_pc_o,
   output logic [1:0]  state_o
);

   if_state_e   state;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        redirect_ok;
   logic        id_flush;
   logic        id_hold;

   assign redirect_ok = redirect_i && is_aligned(redirect_pc_i);
   assign imem_addr_o = {2'b00, pc[31:2]};
   assign state_o     = state;

   // Next-PC mux: redirect > stall > sequential, only while running or faulted.
   always_comb begin
      pc_next = pc;
      case (state)
         ST_BOOT:  pc_next = RESET_PC;
         ST_RUN: begin
            if (redirect_i) begin
               if (redirect_ok) pc_next = redirect_pc_i;
            end else if (!stall_i) begin
               pc_next = pc + 32'd4;
            end
         end
         ST_FAULT: begin
            if (redirect_ok) pc_next = redirect_pc_i;
         end
         default:  pc_next = RESET_PC;
      endcase
   end

   // IF/ID control: drop the slot outside RUN or on any redirect, hold on stall.
   always_comb begin
      id_flush = (state != ST_RUN) || redirect_i;
      id_hold  = stall_i;
   end

   // Controller FSM with the PC and fault reporting registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_BOOT;
         pc         <= RESET_PC;
         fault_o    <= 1'b0;
         fault_pc_o <= 32'h0;
      end else begin
         pc <= pc_next;
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (redirect_i && !redirect_ok) begin
                  state      <= ST_FAULT;
                  fault_o    <= 1'b1;
                  fault_pc_o <= redirect_pc_i;
               end
            end
            ST_FAULT: begin
               if (redirect_ok) begin
                  state   <= ST_RUN;
                  fault_o <= 1'b0;
               end else if (redirect_i) begin
                  fault_pc_o <= redirect_pc_i;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .hold_i  (id_hold),
      .flush_i (id_flush),
      .pc_i    (pc),
      .instr_i (imem_data_i),
      .valid_o (id_valid_o),
      .pc_o    (id_pc_o),
      .instr_o (id_instr_o)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage. Instruction memory returns its own
// word index (word n = n). Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point.
module tb_if_stage;
   import riscv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fault;
   logic [31:0] fault_pc;
   logic [1:0]  state;

   int vectors;
   int miscompares;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .id_valid_o    (id_valid),
      .id_pc_o       (id_pc),
      .id_instr_o    (id_instr),
      .fault_o       (fault),
      .fault_pc_o    (fault_pc),
      .state_o       (state)
   );

   // clock and combinational memory model
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign imem_data = imem_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
   endtask

   task automatic check_fetch(input string tag, input logic [31:0] addr, input logic v,
                              input logic [31:0] ipc, input logic [31:0] instr);
      check({tag, ".addr"},  imem_addr, addr);
      check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, v});
      if (v) begin
         check({tag, ".id_pc"},    id_pc, ipc);
         check({tag, ".id_instr"}, id_instr, instr);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".state"},    {30'h0, state}, {30'h0, ST_BOOT});
      check({tag, ".addr"},     imem_addr, 32'h0);
      check({tag, ".valid"},    {31'h0, id_valid}, 32'h0);
      check({tag, ".id_pc"},    id_pc, 32'h0);
      check({tag, ".id_instr"}, id_instr, 32'h0);
      check({tag, ".fault"},    {31'h0, fault}, 32'h0);
      check({tag, ".fault_pc"}, fault_pc, 32'h0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      step();
      step();
      check_reset("reset");

      // Release with stall and redirect asserted: BOOT must ignore both.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 32'h40);
      step();
      check("boot.state", {30'h0, state}, {30'h0, ST_RUN});
      check_fetch("boot", 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0);

      // Sequential fetch from 0.
      for (int i = 1; i <= 4; i++) begin
         step();
         check_fetch("seq", i, 1'b1, 4 * (i - 1), i - 1);
      end

      // Three-cycle stall with pc at 0x10.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_fetch("stall", 32'h4, 1'b1, 32'hC, 32'h3);
      end
      stall = 1'b0;
      step();
      check_fetch("resume0", 32'h5, 1'b1, 32'h10, 32'h4);
      step();
      check_fetch("resume1", 32'h6, 1'b1, 32'h14, 32'h5);

      // Redirect wins over stall.
      drive(1'b1, 1'b1, 32'h40);
      step();
      check_fetch("redir", 32'h10, 1'b0, 32'h0, 32'h0);
      check("redir.idpc_held", id_pc, 32'h14);
      drive(1'b0, 1'b0, 32'h0);
      step();
      check_fetch("redir1", 32'h11, 1'b1, 32'h40, 32'h10);

      // Misaligned redirect enters FAULT; stall is ignored there.
      drive(1'b0, 1'b1, 32'h42);
      step();
      check("fault.state", {30'h0, state}, {30'h0, ST_FAULT});
      check("fault.flag", {31'h0, fault}, 32'h1);
      check("fault.pc", fault_pc, 32'h42);
      check_fetch("fault", 32'h11, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("fhold.flag", {31'h0, fault}, 32'h1);
         check_fetch("fhold", 32'h11, 1'b0, 32'h0, 32'h0);
      end
      drive(1'b0, 1'b1, 32'h43);
      step();
      check("refault.state", {30'h0, state}, {30'h0, ST_FAULT});
      check("refault.pc", fault_pc, 32'h43);
      check("refault.addr", imem_addr, 32'h11);
      drive(1'b1, 1'b1, 32'h80);
      step();
      check("recover.state", {30'h0, state}, {30'h0, ST_RUN});
      check("recover.flag", {31'h0, fault}, 32'h0);
      check_fetch("recover", 32'h20, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      step();
      check_fetch("recover1", 32'h21, 1'b1, 32'h80, 32'h20);

      // PC wraps from the top word to 0.
      drive(1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      check_fetch("top", 32'h3FFF_FFFF, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      step();
      check_fetch("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
      step();
      check_fetch("wrap1", 32'h1, 1'b1, 32'h0, 32'h0);

      // Asynchronous reset in the middle of FAULT.
      drive(1'b0, 1'b1, 32'h101);
      step();
      check("pre_rst.flag", {31'h0, fault}, 32'h1);
      drive(1'b0, 1'b0, 32'h0);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("reboot.state", {30'h0, state}, {30'h0, ST_RUN});
      check_fetch("reboot", 32'h0, 1'b0, 32'h0, 32'h0);
      step();
      check_fetch("reboot1", 32'h1, 1'b1, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
